int_ctrl: RTL

- Priority interrupt controller directly upstream of the CPU's INT/intack pair.
- Latches edge-triggered requests from N peripheral lines and raises int_o toward the CPU's INT input.
- During the CPU's single-cycle intack it drives the winning source number as the vector on the data bus. The CPU adds 0x07F0 to the vector to index its ISR table.
- A 4-register memory-mapped port, decoded by top-level glue, provides mask, pending, end-of-interrupt and status.

---
 rtl/int_pkg.sv | 28 ++
 rtl/int_prio_enc.sv | 30 +++
 rtl/int_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// ============================================================================
// Module  : int_pkg
// Brief   : Shared types and constants for the priority interrupt controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_pkg;

    localparam int MAX_IRQ = 16;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_EOI     = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // The CPU adds this to the delivered vector to index its ISR table.
    localparam logic [15:0] ISR_TABLE_BASE = 16'h07F0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_e;

endpackage : int_pkg

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
// Module  : int_prio_enc
// Brief   : Combinational lowest-index-first priority encoder (req -> idx, any).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] req_i,
    output logic [3:0]   idx_o,
    output logic         any_o
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx_o = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule : int_prio_enc

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module  : int_ctrl
// Brief   : Edge-triggered priority interrupt controller driving CPU INT/intack,
//           with ENABLE / PENDING / EOI / STATUS register port.
//           Define IRQ_SYNC_EN to add a 2-flop synchronizer on every irq line.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl
    import int_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq,
    output logic             int_o,
    input  logic             intack,
    output logic [15:0]      vector,
    input  logic             cs,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata
);

    // Line state is kept 16 wide; bits at or above N_IRQ are held at zero.
    localparam logic [MAX_IRQ-1:0] VALID_MASK = MAX_IRQ'((32'd1 << N_IRQ) - 32'd1);

    state_e             state_q, state_d;
    logic [N_IRQ-1:0]   irq_q;
    logic [MAX_IRQ-1:0] pending_q, pending_d;
    logic [MAX_IRQ-1:0] enable_q, enable_d;
    logic               in_service_q, in_service_d;
    logic [3:0]         cur_id_q, cur_id_d;
    logic [3:0]         sel_q, sel_d;

    logic [N_IRQ-1:0]   irq_s;
    logic [MAX_IRQ-1:0] rise;
    logic [MAX_IRQ-1:0] req;
    logic [MAX_IRQ-1:0] sel_onehot;
    logic [3:0]         enc_idx;
    logic               enc_any;
    logic               wr_en;
    logic               eoi_wr;
    logic               ack;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    assign rise       = MAX_IRQ'(irq_s & ~irq_q);
    assign req        = pending_q & enable_q;
    assign sel_onehot = MAX_IRQ'(1) << sel_q;
    assign wr_en      = cs & wr;
    assign eoi_wr     = wr_en && (addr == REG_EOI);
    assign ack        = intack && (state_q == REQ);

    int_prio_enc #(
        .N (MAX_IRQ)
    ) u_prio_enc (
        .req_i (req),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enc_any) state_d = REQ;
            REQ: begin
                if (intack) begin
                    state_d = SERV;
                end else if ((req & sel_onehot) == '0) begin
                    state_d = IDLE;
                end
            end
            SERV: if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        int_o  = (state_q == REQ);
        vector = ack ? {12'b0, sel_q} : 16'h0000;
    end

    // Clears are applied before new edges so a same-cycle rising edge survives.
    always_comb begin
        pending_d    = pending_q;
        enable_d     = enable_q;
        in_service_d = in_service_q;
        cur_id_d     = cur_id_q;
        sel_d        = sel_q;

        if (wr_en && (addr == REG_ENABLE)) begin
            enable_d = wdata & VALID_MASK;
        end
        if (wr_en && (addr == REG_PENDING)) begin
            pending_d = pending_d & ~wdata;
        end
        if (eoi_wr) begin
            in_service_d = 1'b0;
        end
        if (ack) begin
            pending_d    = pending_d & ~sel_onehot;
            cur_id_d     = sel_q;
            in_service_d = 1'b1;
        end
        if ((state_q == IDLE) && enc_any) begin
            sel_d = enc_idx;
        end

        pending_d = (pending_d | rise) & VALID_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q        <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= 1'b0;
            cur_id_q     <= 4'd0;
            sel_q        <= 4'd0;
        end else begin
            irq_q        <= irq_s;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            cur_id_q     <= cur_id_d;
            sel_q        <= sel_d;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (addr)
            REG_ENABLE:  rdata = enable_q;
            REG_PENDING: rdata = pending_q;
            REG_EOI:     rdata = {15'b0, in_service_q};
            REG_STATUS:  rdata = {in_service_q, 11'b0, cur_id_q};
            default:     rdata = 16'h0000;
        endcase
    end

endmodule : int_ctrl

`default_nettype wire
